// File: rtl/spi_cmd_rx_pkg.sv
// Shared constants, types and helpers for the SPI command receive path.
// Field offsets describe the default two-byte command frame for the decoder.
package spi_cmd_rx_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int NBYTES_DEF      = 2;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int X_MSB      = 11;
  localparam int X_LSB      = 8;
  localparam int Y_MSB      = 7;
  localparam int Y_LSB      = 4;
  localparam int COLOUR_MSB = 3;
  localparam int COLOUR_LSB = 0;

  typedef enum logic [0:0] {
    RX_IDLE   = 1'b0,
    RX_ACTIVE = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] colour;
  } cmd_frame_t;

  // A frame is committed only when it ends exactly on a byte boundary with NBYTES bytes.
  function automatic logic frame_len_ok(input int unsigned byte_cnt,
                                        input int unsigned bit_cnt,
                                        input int unsigned nbytes);
    return (byte_cnt == nbytes) && (bit_cnt == 32'd0);
  endfunction

endpackage

// File: rtl/spi_cmd_rx_if.sv
// Command stream and status bundle between the SPI receiver and the command decoder.
interface spi_cmd_rx_if import spi_cmd_rx_pkg::*; #(
  parameter int NBYTES = NBYTES_DEF,
  parameter int DEPTH  = DEPTH_DEF
) ();

  logic [SPI_BYTE_W*NBYTES-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  logic                         frame_err;
  logic                         overflow;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready,
    output fifo_count,
    output frame_err,
    output overflow
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready,
    input  fifo_count,
    input  frame_err,
    input  overflow
  );

endinterface

// File: rtl/spi_cmd_rx_fifo.sv
// First-word-fall-through command FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle because the pop frees the slot first.
module spi_cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       ready,
  output logic                       valid,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;

  assign empty_s = (count_r == '0);
  assign full_s  = (count_r == CW'(DEPTH));
  assign pop_s   = ready & ~empty_s;
  assign push_s  = push & (~full_s | pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid = ~empty_s;
  assign rdata = empty_s ? '0 : mem_r[rd_ptr_r];
  assign full  = full_s;
  assign count = count_r;

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave command receiver: synchronises sck/sdi/cs, assembles NBYTES-byte
// frames MSB-first, checks length at cs release and queues good frames in a FIFO.
module spi_cmd_rx import spi_cmd_rx_pkg::*; #(
  parameter int NBYTES      = NBYTES_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sck,
  input  logic         sdi,
  input  logic         cs,
  spi_cmd_rx_if.master cmd
);

  localparam int FW  = SPI_BYTE_W * NBYTES;
  localparam int BCW = $clog2(NBYTES + 2);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] sdi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sck_d_r;
  logic                   cs_d_r;
  logic                   sck_rise_r;
  logic                   cs_rise_r;
  logic                   cs_fall_r;
  logic                   sdi_bit_r;

  rx_state_t              state_r;
  rx_state_t              state_nx;
  logic [2:0]             bit_cnt_r;
  logic [2:0]             bit_cnt_nx;
  logic [BCW-1:0]         byte_cnt_r;
  logic [BCW-1:0]         byte_cnt_nx;
  logic [FW-1:0]          shift_r;
  logic [FW-1:0]          shift_nx;
  logic                   commit_nx;
  logic                   err_nx;

  logic                   commit_r;
  logic [FW-1:0]          frame_r;
  logic                   frame_err_r;
  logic                   overflow_r;

  logic                   fifo_valid_s;
  logic [FW-1:0]          fifo_data_s;
  logic                   fifo_full_s;
  logic [CW-1:0]          fifo_count_s;
  logic                   pop_s;

  // Input synchronisers, previous-cycle copies and registered edge events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_r <= '0;
      sdi_sync_r <= '0;
      cs_sync_r  <= '1;
      sck_d_r    <= 1'b0;
      cs_d_r     <= 1'b1;
      sck_rise_r <= 1'b0;
      cs_rise_r  <= 1'b0;
      cs_fall_r  <= 1'b0;
      sdi_bit_r  <= 1'b0;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], sdi};
      cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], cs};
      sck_d_r    <= sck_sync_r[SYNC_STAGES-1];
      cs_d_r     <= cs_sync_r[SYNC_STAGES-1];
      sck_rise_r <= sck_sync_r[SYNC_STAGES-1] & ~sck_d_r;
      cs_rise_r  <= cs_sync_r[SYNC_STAGES-1] & ~cs_d_r;
      cs_fall_r  <= ~cs_sync_r[SYNC_STAGES-1] & cs_d_r;
      sdi_bit_r  <= sdi_sync_r[SYNC_STAGES-1];
    end
  end

  // Receive FSM next state: frame start, bit shifting and length check at cs release.
  always_comb begin
    state_nx    = state_r;
    bit_cnt_nx  = bit_cnt_r;
    byte_cnt_nx = byte_cnt_r;
    shift_nx    = shift_r;
    commit_nx   = 1'b0;
    err_nx      = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (cs_fall_r) begin
          state_nx    = RX_ACTIVE;
          bit_cnt_nx  = 3'd0;
          byte_cnt_nx = '0;
          shift_nx    = '0;
        end else begin
          state_nx = RX_IDLE;
        end
      end
      RX_ACTIVE: begin
        if (cs_rise_r) begin
          state_nx = RX_IDLE;
          if (frame_len_ok(32'(byte_cnt_r), 32'(bit_cnt_r), NBYTES)) begin
            commit_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end else if (sck_rise_r) begin
          shift_nx   = {shift_r[FW-2:0], sdi_bit_r};
          bit_cnt_nx = bit_cnt_r + 3'd1;
          // Saturate one past NBYTES so overlong frames can never alias back to a good length.
          if ((bit_cnt_r == 3'd7) && (byte_cnt_r != BCW'(NBYTES + 1))) begin
            byte_cnt_nx = byte_cnt_r + BCW'(1);
          end else begin
            byte_cnt_nx = byte_cnt_r;
          end
        end else begin
          state_nx = RX_ACTIVE;
        end
      end
      default: begin
        state_nx = RX_IDLE;
      end
    endcase
  end

  // Receive FSM state, counters and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= RX_IDLE;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
      shift_r    <= '0;
    end else begin
      state_r    <= state_nx;
      bit_cnt_r  <= bit_cnt_nx;
      byte_cnt_r <= byte_cnt_nx;
      shift_r    <= shift_nx;
    end
  end

  assign pop_s = fifo_valid_s & cmd.out_ready;

  // Commit staging and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_r    <= 1'b0;
      frame_r     <= '0;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      commit_r    <= commit_nx;
      frame_r     <= commit_nx ? shift_r : frame_r;
      frame_err_r <= err_nx;
      overflow_r  <= commit_r & fifo_full_s & ~pop_s;
    end
  end

  spi_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (commit_r),
    .wdata (frame_r),
    .ready (cmd.out_ready),
    .valid (fifo_valid_s),
    .rdata (fifo_data_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  assign cmd.out_valid  = fifo_valid_s;
  assign cmd.out_data   = fifo_data_s;
  assign cmd.fifo_count = fifo_count_s;
  assign cmd.frame_err  = frame_err_r;
  assign cmd.overflow   = overflow_r;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: latency, length errors, overflow, full-with-pop, reset, idle sck.
module tb_spi_cmd_rx;

  localparam int NB    = 2;
  localparam int DP    = 4;
  localparam int SYNC  = 2;
  localparam int LAT_N = SYNC + 3;

  logic clk;
  logic reset;
  logic sck;
  logic sdi;
  logic cs;

  int n_checks;
  int n_fail;
  int err_cnt;
  int ovf_cnt;
  int lat;
  logic [15:0] rx_q [$];

  spi_cmd_rx_if #(.NBYTES(NB), .DEPTH(DP)) cmd ();

  spi_cmd_rx #(.NBYTES(NB), .DEPTH(DP), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .sck   (sck),
    .sdi   (sdi),
    .cs    (cs),
    .cmd   (cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample pulses and accepted frames mid-low-phase, after negedge-driven inputs settle.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      if (cmd.frame_err) err_cnt++;
      if (cmd.overflow) ovf_cnt++;
      if (cmd.out_valid && cmd.out_ready) rx_q.push_back(cmd.out_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < rx_q.size()) return {16'h0000, rx_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic spi_bits(input logic [31:0] data, input int nbits, input int half);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = data[i];
      repeat (half) @(negedge clk);
      sck = 1'b1;
      repeat (half) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  // Leaves cs high right at a falling clk edge, so the next rising edge is the first to sample it.
  task automatic spi_frame(input logic [31:0] data, input int nbits, input int half);
    @(negedge clk);
    cs = 1'b0;
    repeat (2 * half) @(negedge clk);
    spi_bits(data, nbits, half);
    repeat (half) @(negedge clk);
    cs = 1'b1;
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
    #2;
  endtask

  task automatic set_ready(input logic val);
    @(negedge clk);
    cmd.out_ready = val;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0; err_cnt = 0; ovf_cnt = 0;
    reset = 1'b0; sck = 1'b0; sdi = 1'b0; cs = 1'b1; cmd.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check_eq("rst_valid", cmd.out_valid, 32'd0);
    check_eq("rst_data", cmd.out_data, 32'd0);
    check_eq("rst_count", cmd.fifo_count, 32'd0);
    check_eq("rst_err", cmd.frame_err, 32'd0);
    check_eq("rst_ovf", cmd.overflow, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Single good frame with latency measurement.
    spi_frame(32'hA53C, 16, 4);
    lat = 0;
    do begin
      @(negedge clk);
      #2;
      lat++;
    end while (!cmd.out_valid && lat < 30);
    check_eq("t1_latency", lat, LAT_N);
    check_eq("t1_data", cmd.out_data, 32'hA53C);
    @(negedge clk);
    #2;
    check_eq("t1_valid_drop", cmd.out_valid, 32'd0);
    settle();
    check_eq("t1_nrx", rx_q.size(), 32'd1);
    check_eq("t1_rx0", q_at(0), 32'hA53C);
    rx_q.delete();

    // Short and long frames.
    spi_frame(32'h2A5A, 15, 4);
    settle();
    check_eq("t2_err15", err_cnt, 32'd1);
    spi_frame(32'h1A5A5, 17, 4);
    settle();
    check_eq("t2_err17", err_cnt, 32'd2);
    check_eq("t2_nrx", rx_q.size(), 32'd0);
    check_eq("t2_count", cmd.fifo_count, 32'd0);
    check_eq("t2_valid", cmd.out_valid, 32'd0);

    // Fill with consumer stalled, then overflow on the fifth frame.
    set_ready(1'b0);
    for (int f = 1; f <= 5; f++) begin
      spi_frame({16'h0000, 8'(f), 8'(f)}, 16, 4);
      settle();
    end
    check_eq("t3_count", cmd.fifo_count, 32'd4);
    check_eq("t3_ovf", ovf_cnt, 32'd1);
    check_eq("t3_head", cmd.out_data, 32'h0101);
    set_ready(1'b1);
    repeat (8) @(negedge clk);
    #2;
    check_eq("t3_nrx", rx_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_drain", q_at(i), {16'h0000, 8'(i + 1), 8'(i + 1)});
    end
    check_eq("t3_empty", cmd.fifo_count, 32'd0);
    rx_q.delete();

    // Full FIFO with a pop exactly in the commit cycle of the fifth frame.
    set_ready(1'b0);
    for (int f = 1; f <= 4; f++) begin
      spi_frame({16'h0000, 4'(f), 4'(f), 4'(f), 4'(f)}, 16, 4);
      settle();
    end
    check_eq("t4_full", cmd.fifo_count, 32'd4);
    spi_frame(32'h5555, 16, 4);
    repeat (SYNC + 2) @(negedge clk);
    cmd.out_ready = 1'b1;
    @(negedge clk);
    cmd.out_ready = 1'b0;
    settle();
    check_eq("t4_count", cmd.fifo_count, 32'd4);
    check_eq("t4_ovf", ovf_cnt, 32'd1);
    set_ready(1'b1);
    repeat (8) @(negedge clk);
    #2;
    check_eq("t4_nrx", rx_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_order", q_at(i), {16'h0000, 4'(i + 1), 4'(i + 1), 4'(i + 1), 4'(i + 1)});
    end
    rx_q.delete();

    // Reset in the middle of a frame.
    @(negedge clk);
    cs = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(32'h155, 9, 4);
    @(negedge clk);
    reset = 1'b0;
    cs = 1'b1;
    sdi = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("t5_rst_count", cmd.fifo_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    spi_frame(32'h1234, 16, 4);
    settle();
    check_eq("t5_nrx", rx_q.size(), 32'd1);
    check_eq("t5_rx0", q_at(0), 32'h1234);
    check_eq("t5_err", err_cnt, 32'd2);
    rx_q.delete();

    // sck activity while deselected, at clk/8 then clk/4.
    @(negedge clk);
    spi_bits(32'h3FF, 10, 4);
    spi_frame(32'hFF00, 16, 4);
    settle();
    check_eq("t6_nrx", rx_q.size(), 32'd1);
    check_eq("t6_rx0", q_at(0), 32'hFF00);
    check_eq("t6_err", err_cnt, 32'd2);
    rx_q.delete();
    @(negedge clk);
    spi_bits(32'h2AA, 10, 2);
    spi_frame(32'hFF00, 16, 2);
    settle();
    spi_frame(32'h5AC3, 16, 2);
    settle();
    check_eq("t7_nrx", rx_q.size(), 32'd2);
    check_eq("t7_rx0", q_at(0), 32'hFF00);
    check_eq("t7_rx1", q_at(1), 32'h5AC3);
    check_eq("t7_err", err_cnt, 32'd2);
    check_eq("t7_ovf", ovf_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
